// File: rtl/dma_handshake_monitor.sv
// Passive DMA bus handshake monitor: per-channel FSMs, transfer counters, sticky error flags.
// Optional per-channel max DREQ->DACK latency tracking when DMA_MON_LATENCY_EN is defined.
module dma_handshake_monitor #(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16,
  parameter int LAT_W   = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NUM_CH-1:0]           DREQ,
  input  logic [NUM_CH-1:0]           DACK,
  input  logic                        IOR_N,
  input  logic                        IOW_N,
  input  logic                        clr,
  output logic [3:0]                  err_flags,
  output logic [$clog2(NUM_CH)-1:0]   err_ch,
  output logic                        err_pulse,
  output logic [NUM_CH*CNT_W-1:0]     xfer_cnt,
  output logic [NUM_CH*LAT_W-1:0]     max_lat
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;

  logic [1:0]       r_st   [NUM_CH];
  logic [WC_W-1:0]  r_wcnt [NUM_CH];
  logic [CNT_W-1:0] r_cnt  [NUM_CH];

  logic [NUM_CH-1:0] r_dreq_q;
  logic [NUM_CH-1:0] r_dack_q;
  logic              r_strb_q;
  logic              r_valid;

  logic [3:0]        r_flags;
  logic [CH_W-1:0]   r_ch;
  logic              r_pulse;

  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_to;
  logic [NUM_CH-1:0] w_stay;
  logic              w_fall;
  logic [3:0]        w_new;
  logic [CH_W-1:0]   w_tag;

  function automatic logic [CH_W-1:0] f_low(input logic [NUM_CH-1:0] v);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // Edge-based checks are masked until the previous-sample registers hold real data.
  always_comb begin
    w_stay = '0;
    w_to   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_stay[i] = (r_st[i] == S_PEND) && DREQ[i] && !DACK[i];
      w_to[i]   = w_stay[i] && (r_wcnt[i] == WC_W'(TIMEOUT - 1));
    end
    w_rise   = DACK & ~r_dack_q & ~r_dreq_q & {NUM_CH{r_valid}};
    w_fall   = r_valid && r_strb_q && !(IOR_N && IOW_N);
    w_new[0] = |(DACK & (DACK - NUM_CH'(1)));
    w_new[1] = |w_rise;
    w_new[2] = !IOR_N && !IOW_N;
    w_new[3] = |w_to;
  end

  always_comb begin
    w_tag = '0;
    if (w_new[0])      w_tag = f_low(DACK);
    else if (w_new[1]) w_tag = f_low(w_rise);
    else if (w_new[2]) w_tag = f_low(DACK);
    else if (w_new[3]) w_tag = f_low(w_to);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dreq_q <= '0;
      r_dack_q <= '0;
      r_strb_q <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      r_dreq_q <= DREQ;
      r_dack_q <= DACK;
      r_strb_q <= IOR_N & IOW_N;
      r_valid  <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_st[i]   <= S_IDLE;
        r_wcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        unique case (r_st[i])
          S_IDLE: begin
            if (DACK[i]) begin
              r_st[i]   <= S_ACT;
              r_wcnt[i] <= '0;
            end else if (DREQ[i]) begin
              r_st[i]   <= S_PEND;
              r_wcnt[i] <= WC_W'(1);
            end
          end
          S_PEND: begin
            if (DACK[i]) begin
              r_st[i]   <= S_ACT;
              r_wcnt[i] <= '0;
            end else if (!DREQ[i]) begin
              r_st[i]   <= S_IDLE;
              r_wcnt[i] <= '0;
            end else if (r_wcnt[i] != WC_W'(TIMEOUT)) begin
              r_wcnt[i] <= r_wcnt[i] + WC_W'(1);
            end
          end
          S_ACT: begin
            if (!DACK[i]) r_st[i] <= S_IDLE;
          end
          default: begin
            r_st[i]   <= S_IDLE;
            r_wcnt[i] <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr)
          r_cnt[i] <= '0;
        else if (w_fall && DACK[i] && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // A new error in the clearing cycle survives the clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_flags <= '0;
      r_ch    <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_flags <= clr ? w_new : (r_flags | w_new);
      r_pulse <= clr ? (|w_new) : (|(w_new & ~r_flags));
      if ((w_new != 4'd0) && (clr || (r_flags == 4'd0)))
        r_ch <= w_tag;
      else if (clr)
        r_ch <= '0;
    end
  end

  assign err_flags = r_flags;
  assign err_ch    = r_ch;
  assign err_pulse = r_pulse;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign xfer_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

`ifdef DMA_MON_LATENCY_EN
  logic [LAT_W-1:0] r_lat [NUM_CH];
  logic [LAT_W-1:0] r_max [NUM_CH];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_lat[i] <= '0;
        r_max[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((r_st[i] == S_IDLE) && DREQ[i] && !DACK[i])
          r_lat[i] <= LAT_W'(1);
        else if (w_stay[i] && (r_lat[i] != '1))
          r_lat[i] <= r_lat[i] + LAT_W'(1);
        if (clr)
          r_max[i] <= '0;
        else if ((r_st[i] == S_PEND) && DACK[i] && (r_lat[i] > r_max[i]))
          r_max[i] <= r_lat[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lat
    assign max_lat[g*LAT_W +: LAT_W] = r_max[g];
  end
`else
  assign max_lat = '0;
`endif

endmodule

// File: tb/tb_dma_handshake_monitor.sv
// Directed bench for dma_handshake_monitor (default parameters).
// Latency checks follow DMA_MON_LATENCY_EN when defined.
module tb_dma_handshake_monitor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  DREQ = '0;
  logic [3:0]  DACK = '0;
  logic        IOR_N = 1'b1;
  logic        IOW_N = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  err_flags;
  logic [1:0]  err_ch;
  logic        err_pulse;
  logic [63:0] xfer_cnt;
  logic [31:0] max_lat;

  int n_cmp = 0;
  int n_bad = 0;

  dma_handshake_monitor dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DACK(DACK),
    .IOR_N(IOR_N), .IOW_N(IOW_N), .clr(clr),
    .err_flags(err_flags), .err_ch(err_ch), .err_pulse(err_pulse),
    .xfer_cnt(xfer_cnt), .max_lat(max_lat)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] cnt(input int i);
    return xfer_cnt[i*16 +: 16];
  endfunction

  function automatic logic [7:0] lat(input int i);
    return max_lat[i*8 +: 8];
  endfunction

  initial begin
    tick(2);
    chk("rst_flags", err_flags, 4'h0);
    chk("rst_ch", err_ch, 2'd0);
    chk("rst_pulse", err_pulse, 1'b0);
    chk("rst_cnt", xfer_cnt, 64'h0);
    chk("rst_lat", max_lat, 32'h0);
    RESET = 1'b0;
    tick();

    // ch1 request, ack after 3 cycles, one read strobe
    DREQ = 4'b0010;
    tick(3);
    DACK = 4'b0010;
    tick();
    IOR_N = 1'b0;
    tick();
    IOR_N = 1'b1;
    tick();
    chk("t1_cnt1", cnt(1), 16'd1);
    chk("t1_flags", err_flags, 4'h0);
`ifdef DMA_MON_LATENCY_EN
    chk("t1_lat1", lat(1), 8'd3);
`endif
    DREQ = '0;
    DACK = '0;
    tick();

    // ch2 timeout after 16 waiting cycles
    DREQ = 4'b0100;
    tick(15);
    chk("t2_pre_flags", err_flags, 4'h0);
    chk("t2_pre_pulse", err_pulse, 1'b0);
    tick();
    chk("t2_flags", err_flags, 4'b1000);
    chk("t2_ch", err_ch, 2'd2);
    chk("t2_pulse", err_pulse, 1'b1);
    tick();
    chk("t2_pulse_end", err_pulse, 1'b0);
    chk("t2_sticky", err_flags, 4'b1000);
    DREQ = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_flags", err_flags, 4'h0);
    chk("clr_ch", err_ch, 2'd0);
    chk("clr_cnt1", cnt(1), 16'd0);

    // multi-DACK on ch0/ch1, then clear coincident with a repeat
    DREQ = 4'b0011;
    tick();
    DACK = 4'b0011;
    tick();
    chk("t3_flags", err_flags, 4'b0001);
    chk("t3_ch", err_ch, 2'd0);
    chk("t3_pulse", err_pulse, 1'b1);
    DACK = '0;
    tick();
    chk("t3_pulse_end", err_pulse, 1'b0);
    clr = 1'b1;
    DACK = 4'b0011;
    tick();
    chk("t3_clr_err_flags", err_flags, 4'b0001);
    chk("t3_clr_err_pulse", err_pulse, 1'b1);
    clr = 1'b0;
    DACK = '0;
    DREQ = '0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_clr_flags", err_flags, 4'h0);
    chk("t3_clr_ch", err_ch, 2'd0);

    // ch3 ack without request, then both strobes low
    DACK = 4'b1000;
    tick();
    chk("t4a_flags", err_flags, 4'b0010);
    chk("t4a_ch", err_ch, 2'd3);
    chk("t4a_pulse", err_pulse, 1'b1);
    IOR_N = 1'b0;
    IOW_N = 1'b0;
    tick();
    chk("t4b_flags", err_flags, 4'b0110);
    chk("t4b_ch", err_ch, 2'd3);
    chk("t4b_pulse", err_pulse, 1'b1);
    chk("t4b_cnt3", cnt(3), 16'd1);
    IOR_N = 1'b1;
    IOW_N = 1'b1;
    DACK = '0;
    tick();

    // ch0 burst: long write strobe counts once, then two pulses
    DREQ = 4'b0001;
    tick();
    DACK = 4'b0001;
    tick();
    IOW_N = 1'b0;
    tick(5);
    for (int k = 0; k < 2; k++) begin
      IOW_N = 1'b1;
      tick();
      IOW_N = 1'b0;
      tick();
    end
    IOW_N = 1'b1;
    tick();
    chk("t5_cnt0", cnt(0), 16'd3);
    chk("t5_flags", err_flags, 4'b0110);
    chk("t5_pulse", err_pulse, 1'b0);
    IOW_N = 1'b0;
    tick();
    chk("t5_cnt0_b", cnt(0), 16'd4);
    #2 RESET = 1'b1;
    #1;
    chk("t5_rst_flags", err_flags, 4'h0);
    chk("t5_rst_ch", err_ch, 2'd0);
    chk("t5_rst_cnt", xfer_cnt, 64'h0);
    DREQ = '0;
    tick();
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_rel_pulse", err_pulse, 1'b0);
    end
    chk("t5_rel_flags", err_flags, 4'h0);
    chk("t5_rel_cnt0", cnt(0), 16'd0);
    DACK = '0;
    IOW_N = 1'b1;
    tick(2);

    // ch2 latencies 5 then 3
    DREQ = 4'b0100;
    tick(5);
    DACK = 4'b0100;
    tick();
    DACK = '0;
    DREQ = '0;
    tick();
`ifdef DMA_MON_LATENCY_EN
    chk("t6_lat2_first", lat(2), 8'd5);
`endif
    DREQ = 4'b0100;
    tick(3);
    DACK = 4'b0100;
    tick();
    DACK = '0;
    DREQ = '0;
    tick();
`ifdef DMA_MON_LATENCY_EN
    chk("t6_lat2", lat(2), 8'd5);
`else
    chk("t6_lat_off", max_lat, 32'h0);
`endif
    chk("t6_flags", err_flags, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
